sync_fifo_flex: RTL and testbench

//  Parametrised single-clock FIFO, successor to the basic sync FIFO. Any depth >= 2 (power of 2 not required);
//  all DEPTH entries usable; occupancy count; programmable almost-full/almost-empty; overflow/underflow pulses;

---
 rtl/sync_fifo_pkg.sv | 15 +
 rtl/sync_fifo_mem.sv | 36 +++
 rtl/sync_fifo_flex.sv | 160 ++++++++++++++++
 tb/tb_sync_fifo_flex.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the flexible single-clock FIFO family.
// Mode selection enum and the count-width helper used by every instance.
package sync_fifo_pkg;

    typedef enum logic [0:0] {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Count must be able to represent every value 0..depth inclusive.
    function automatic int fifo_cw(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port storage: one write port, one registered read port.
// The array has no reset; only the read data register returns to zero.
module sync_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Storage write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port; holds its value when no read is issued
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= {DATA_WIDTH{1'b0}};
        end else if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo_flex.sv
// Parametrised single-clock FIFO: any depth >= 2, occupancy count, programmable
// almost-full/almost-empty, overflow/underflow pulses, standard or FWFT read.
module sync_fifo_flex
    import sync_fifo_pkg::*;
#(
    parameter int         DATA_WIDTH = 8,
    parameter int         DEPTH      = 256,
    parameter fifo_mode_e MODE       = FIFO_STD,
    parameter int         AF_LEVEL   = DEPTH - 2,
    parameter int         AE_LEVEL   = 2,
    localparam int        CW         = fifo_cw(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int            PW      = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);
    localparam logic          IS_FWFT = (MODE == FIFO_FWFT);

    if (DEPTH < 2) begin : g_bad_depth
        $fatal(1, "sync_fifo_flex: DEPTH must be >= 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $fatal(1, "sync_fifo_flex: AF_LEVEL must be in 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $fatal(1, "sync_fifo_flex: AE_LEVEL must be in 0..DEPTH-1");
    end
    if (MODE != FIFO_STD && MODE != FIFO_FWFT) begin : g_bad_mode
        $fatal(1, "sync_fifo_flex: unknown MODE");
    end

    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] mem_count_r;
    logic          valid_r;
    logic          empty_r;
    logic          full_r;
    logic          af_r;
    logic          ae_r;
    logic          ovf_r;
    logic          unf_r;

    logic          wr_acc_s;
    logic          rd_acc_s;
    logic          mem_rd_s;
    logic          valid_nxt_s;
    logic          empty_nxt_s;
    logic [CW-1:0] count_nxt_s;
    logic [CW-1:0] mem_count_nxt_s;

    // Accept decisions and next-state values; flags are all derived from pre-edge state
    always_comb begin
        wr_acc_s = wr_en && !full_r;
        rd_acc_s = rd_en && !empty_r;

        // FWFT prefetches into the output register whenever it is free or being acknowledged
        if (IS_FWFT) begin
            mem_rd_s    = (!valid_r || rd_en) && (mem_count_r != {CW{1'b0}});
            valid_nxt_s = mem_rd_s || (valid_r && !rd_en);
        end else begin
            mem_rd_s    = rd_acc_s;
            valid_nxt_s = rd_acc_s;
        end

        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_nxt_s = count_r + CW'(1'b1);
            2'b01:   count_nxt_s = count_r - CW'(1'b1);
            default: count_nxt_s = count_r;
        endcase

        case ({wr_acc_s, mem_rd_s})
            2'b10:   mem_count_nxt_s = mem_count_r + CW'(1'b1);
            2'b01:   mem_count_nxt_s = mem_count_r - CW'(1'b1);
            default: mem_count_nxt_s = mem_count_r;
        endcase

        if (IS_FWFT) begin
            empty_nxt_s = !valid_nxt_s;
        end else begin
            empty_nxt_s = (count_nxt_s == {CW{1'b0}});
        end
    end

    // Pointers, occupancy and registered status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            mem_count_r <= {CW{1'b0}};
            valid_r     <= 1'b0;
            empty_r     <= 1'b1;
            full_r      <= 1'b0;
            af_r        <= 1'b0;
            ae_r        <= 1'b1;
            ovf_r       <= 1'b0;
            unf_r       <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= (wr_ptr_r == LAST_C) ? {PW{1'b0}} : wr_ptr_r + PW'(1'b1);
            end
            if (mem_rd_s) begin
                rd_ptr_r <= (rd_ptr_r == LAST_C) ? {PW{1'b0}} : rd_ptr_r + PW'(1'b1);
            end
            count_r     <= count_nxt_s;
            mem_count_r <= mem_count_nxt_s;
            valid_r     <= valid_nxt_s;
            empty_r     <= empty_nxt_s;
            full_r      <= (count_nxt_s == DEPTH_C);
            af_r        <= (count_nxt_s >= AF_C);
            ae_r        <= (count_nxt_s <= AE_C);
            ovf_r       <= wr_en && full_r;
            unf_r       <= rd_en && empty_r;
        end
    end

    // The memory read register doubles as the output register in both modes
    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (PW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc_s),
        .wr_addr (wr_ptr_r),
        .wr_data (din),
        .rd_en   (mem_rd_s),
        .rd_addr (rd_ptr_r),
        .rd_data (dout)
    );

    assign valid        = valid_r;
    assign full         = full_r;
    assign empty        = empty_r;
    assign almost_full  = af_r;
    assign almost_empty = ae_r;
    assign count        = count_r;
    assign overflow     = ovf_r;
    assign underflow    = unf_r;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Three FIFO instances (STD depth 5, STD depth 8, FWFT depth 4) share one stimulus
// stream and are each checked every cycle against a queue-based model.
module tb_sync_fifo_flex;
    import sync_fifo_pkg::*;

    localparam int DM  [3] = '{5, 8, 4};
    localparam int AFM [3] = '{3, 6, 2};
    localparam int AEM [3] = '{2, 2, 1};
    localparam bit FWM [3] = '{1'b0, 1'b0, 1'b1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] din = 8'h00;

    logic [7:0] dout_w  [3];
    logic       valid_w [3];
    logic       full_w  [3];
    logic       empty_w [3];
    logic       af_w    [3];
    logic       ae_w    [3];
    logic       ovf_w   [3];
    logic       unf_w   [3];
    logic [3:0] cnt_w   [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int CWG = fifo_cw(DM[g]);
        logic [CWG-1:0] cnt_g;
        sync_fifo_flex #(
            .DATA_WIDTH (8),
            .DEPTH      (DM[g]),
            .MODE       (FWM[g] ? FIFO_FWFT : FIFO_STD),
            .AF_LEVEL   (AFM[g]),
            .AE_LEVEL   (AEM[g])
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .wr_en        (wr_en),
            .din          (din),
            .rd_en        (rd_en),
            .dout         (dout_w[g]),
            .valid        (valid_w[g]),
            .full         (full_w[g]),
            .empty        (empty_w[g]),
            .almost_full  (af_w[g]),
            .almost_empty (ae_w[g]),
            .count        (cnt_g),
            .overflow     (ovf_w[g]),
            .underflow    (unf_w[g])
        );
        assign cnt_w[g] = 4'(cnt_g);
    end

    // Reference model: queue of held words (FWFT: head included), visible-head flag
    logic [7:0] mq     [3][$];
    logic [7:0] m_dout [3];
    bit         m_hv   [3];
    bit         m_ovf  [3];
    bit         m_unf  [3];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                mq[k].delete();
                m_dout[k] = 8'h00;
                m_hv[k]   = 1'b0;
                m_ovf[k]  = 1'b0;
                m_unf[k]  = 1'b0;
            end else begin
                int s;
                bit ra;
                bit keep;
                s = mq[k].size();
                m_ovf[k] = wr_en && (s == DM[k]);
                if (!FWM[k]) begin
                    m_unf[k] = rd_en && (s == 0);
                    if (rd_en && s > 0) begin
                        m_dout[k] = mq[k].pop_front();
                        m_hv[k]   = 1'b1;
                    end else begin
                        m_hv[k] = 1'b0;
                    end
                    if (wr_en && s < DM[k]) mq[k].push_back(din);
                end else begin
                    ra       = rd_en && m_hv[k];
                    m_unf[k] = rd_en && !m_hv[k];
                    keep     = m_hv[k] && !ra;
                    if (ra) void'(mq[k].pop_front());
                    // a word already stored before this edge becomes the visible head
                    m_hv[k] = keep || ((s - (m_hv[k] ? 1 : 0)) > 0);
                    if (wr_en && s < DM[k]) mq[k].push_back(din);
                    if (m_hv[k]) m_dout[k] = mq[k][0];
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            int sz;
            sz = mq[k].size();
            chk("count",     k, 32'(cnt_w[k]),   32'(sz));
            chk("full",      k, 32'(full_w[k]),  32'(sz == DM[k]));
            chk("empty",     k, 32'(empty_w[k]), 32'(FWM[k] ? !m_hv[k] : (sz == 0)));
            chk("valid",     k, 32'(valid_w[k]), 32'(m_hv[k]));
            chk("almost_f",  k, 32'(af_w[k]),    32'(sz >= AFM[k]));
            chk("almost_e",  k, 32'(ae_w[k]),    32'(sz <= AEM[k]));
            chk("overflow",  k, 32'(ovf_w[k]),   32'(m_ovf[k]));
            chk("underflow", k, 32'(unf_w[k]),   32'(m_unf[k]));
            chk("dout",      k, 32'(dout_w[k]),  32'(m_dout[k]));
        end
    endtask

    task automatic cyc(input logic w, input logic r, input logic [7:0] d, input logic rs);
        wr_en = w;
        rd_en = r;
        din   = d;
        rst   = rs;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int unsigned pw;
        int unsigned pr;
        pw = 50;
        pr = 50;

        // reset state
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk("rst_count", k, 32'(cnt_w[k]),   32'd0);
            chk("rst_empty", k, 32'(empty_w[k]), 32'd1);
            chk("rst_ae",    k, 32'(ae_w[k]),    32'd1);
            chk("rst_af",    k, 32'(af_w[k]),    32'd0);
        end

        // mid-stream reset with five words held in the depth-8 instance
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 8'h15, 1'b0);
        chk("pre_rst_count", 1, 32'(cnt_w[1]),  32'd5);
        chk("pre_rst_dout",  1, 32'(dout_w[1]), 32'h10);
        cyc(1'b1, 1'b1, 8'h77, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk("mid_rst_count", k, 32'(cnt_w[k]),   32'd0);
            chk("mid_rst_empty", k, 32'(empty_w[k]), 32'd1);
            chk("mid_rst_valid", k, 32'(valid_w[k]), 32'd0);
            chk("mid_rst_dout",  k, 32'(dout_w[k]),  32'd0);
        end
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);

        // fill/drain depth 5 with pointers pre-advanced so the drain wraps
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'hEE, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 8'(i + 1), 1'b0);
            chk("fill_count", 0, 32'(cnt_w[0]), 32'(i + 1));
        end
        chk("fill_full", 0, 32'(full_w[0]), 32'd1);
        cyc(1'b1, 1'b0, 8'h06, 1'b0);
        chk("ovf_pulse", 0, 32'(ovf_w[0]), 32'd1);
        chk("ovf_count", 0, 32'(cnt_w[0]), 32'd5);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("ovf_clear", 0, 32'(ovf_w[0]), 32'd0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 8'h00, 1'b0);
            chk("drain_dout",  0, 32'(dout_w[0]),  32'(i + 1));
            chk("drain_valid", 0, 32'(valid_w[0]), 32'd1);
        end
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        chk("unf_pulse", 0, 32'(unf_w[0]),   32'd1);
        chk("unf_empty", 0, 32'(empty_w[0]), 32'd1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);

        // thresholds on depth 8: AF=6, AE=2
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
            chk("af_rise", 1, 32'(af_w[1]), 32'(i == 5));
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 8'h00, 1'b0);
            chk("ae_rise", 1, 32'(ae_w[1]), 32'(i == 3));
        end
        cyc(1'b0, 1'b0, 8'h00, 1'b1);

        // simultaneous read/write at count 3
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b1, 8'(8'h43 + i), 1'b0);
            chk("rw_count", 1, 32'(cnt_w[1]),  32'd3);
            chk("rw_dout",  1, 32'(dout_w[1]), 32'(8'h40 + i));
        end
        cyc(1'b0, 1'b0, 8'h00, 1'b1);

        // FWFT depth 4: first word appears two edges after the write
        cyc(1'b1, 1'b0, 8'hA5, 1'b0);
        chk("fwft_lat1", 2, 32'(valid_w[2]), 32'd0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("fwft_lat2_v", 2, 32'(valid_w[2]), 32'd1);
        chk("fwft_lat2_d", 2, 32'(dout_w[2]),  32'hA5);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'(8'hB0 + i), 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 8'h00, 1'b0);
            chk("fwft_str_v", 2, 32'(valid_w[2]), 32'd1);
            chk("fwft_str_d", 2, 32'(dout_w[2]),  32'(8'hB0 + i));
        end
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        chk("fwft_last_v", 2, 32'(valid_w[2]), 32'd0);
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        chk("fwft_unf", 2, 32'(unf_w[2]), 32'd1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);

        // random traffic with drifting write/read biases and rare resets
        for (int c = 0; c < 10000; c++) begin
            if (c % 500 == 0) begin
                pw = $urandom_range(15, 85);
                pr = $urandom_range(15, 85);
            end
            cyc($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
                8'($urandom), $urandom_range(0, 996) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
